ula_sequenciador: RTL
=====================

Name: ula_sequenciador

Overview:
Operator-side initiator for the ALU. It debounces a push button and uses each press to step through operand entry from the switches: A, then B plus operation and mode. It then issues the operation to the ALU over a valid/ready handshake, waits for the result, and holds the result and flags for display until the next press. It sits between the board inputs (SW/KEY) and the ALU core, and returns the ALU outputs toward the LEDs.

Parameters:
LARGURA, 6, operand width.
DEBOUNCE_CICLOS, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
TIMEOUT, 255, maximum cycles from entering EXECUTA until the result arrives.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
reset_n  in  1  reset, asynchronous, active-low.
i_botao  in  1  raw push button, active-low (pressed = 0), asynchronous to the clock.
i_dado  in  LARGURA  operand value from the switches.
i_operacao  in  3  operation code.
i_modo  in  1  1 = logic operation, 0 = arithmetic operation.
o_A  out  LARGURA  operand A to the ALU.
o_B  out  LARGURA  operand B to the ALU.
o_operacao  out  3  operation code to the ALU.
o_modo  out  1  mode to the ALU.
o_valido  out  1  request valid.
i_pronto  in  1  ALU accepts the request.
i_res_valido  in  1  ALU result valid, one-cycle pulse.
i_resultado  in  7  ALU result.
i_overflow  in  1  ALU overflow flag.
i_zero  in  1  ALU zero flag.
o_resultado  out  7  captured result.
o_overflow  out  1  captured overflow flag.
o_zero  out  1  captured zero flag.
o_erro  out  1  timeout indicator.
o_estado  out  3  current state code, for the LEDs.

Behaviour:
- Reset (reset_n = 0, takes effect immediately, any state):
  - All outputs 0; state = CARREGA_A.
  - Synchronizer flops and debounced level = 1 (button released).
  - Debounce counter and timeout counter = 0.
- Debounce:
  - i_botao passes through a 2-flop synchronizer.
  - When the synchronized level differs from the debounced level, a counter runs; any return to the debounced level clears the counter.
  - When the counter reaches DEBOUNCE_CICLOS, the debounced level updates.
  - A debounced 1→0 transition produces a one-cycle "press" pulse. Release generates nothing.
- State codes: CARREGA_A = 0, CARREGA_B = 1, EXECUTA = 2, AGUARDA = 3, EXIBE = 4.
- CARREGA_A: on press, o_A <= i_dado; next state CARREGA_B.
- CARREGA_B: on press, o_B <= i_dado, o_operacao <= i_operacao, o_modo <= i_modo; next state EXECUTA.
- EXECUTA:
  - o_valido = 1, as a registered output asserted on the cycle of entry.
  - o_A, o_B, o_operacao and o_modo stay stable while o_valido = 1.
  - A transfer occurs on the first cycle with o_valido = 1 and i_pronto = 1; o_valido drops on the next cycle and the state moves to AGUARDA.
  - i_res_valido is ignored in this state. The ALU returns a result at least 1 cycle after the transfer.
- AGUARDA: on i_res_valido = 1, capture i_resultado, i_overflow and i_zero into the outputs; next state EXIBE.
- Timeout:
  - The timeout counter clears on entry to EXECUTA and increments every cycle spent in EXECUTA or AGUARDA.
  - When it reaches TIMEOUT with no capture: o_erro = 1, o_valido = 0, o_resultado/o_overflow/o_zero = 0, state = EXIBE.
  - If i_res_valido arrives on the same cycle as the timeout, the capture wins and o_erro stays 0.
- EXIBE: outputs hold. On press: o_erro cleared, next state CARREGA_A. Captured results hold until the next capture or timeout.
- Presses during EXECUTA or AGUARDA are discarded, not queued.
- o_estado is always the current state code.

Test Plan:
1. Simulation overrides: DEBOUNCE_CICLOS = 4, TIMEOUT = 16. Press with i_dado = 5; press with i_dado = 3, op = 000, modo = 0. Responder asserts i_pronto 2 cycles after o_valido rises and i_res_valido 3 cycles later with 7'd8 → o_A = 5, o_B = 3, o_valido high exactly 3 cycles, o_resultado = 8, o_zero = 0, o_estado = 4.
2. Bounce: two 2-cycle low glitches on i_botao → o_estado stays 0. Hold low for 6 cycles → exactly one advance to state 1. Keep held 50 cycles → no further advance.
3. Timeout: responder holds i_pronto = 1 and never asserts i_res_valido → 16 cycles after entering EXECUTA: o_erro = 1, o_resultado = 0, o_estado = 4. Next press → o_erro = 0, o_estado = 0.
4. Backpressure: i_pronto held 0 for 10 cycles, with presses injected meanwhile → o_valido stays 1, o_A and o_B unchanged, state stays 2, no extra advance.
5. Flags: result 7'b1000000 with i_overflow = 1 and i_zero = 1 → captured o_resultado = 64, o_overflow = 1, o_zero = 1, all held through 100 idle cycles.
6. Reset asserted mid-AGUARDA, with no clock edge → all outputs 0 and o_estado = 0 immediately. After release, normal operation resumes.

Source files
------------

// File: rtl/ula_sequenciador.sv
// ---------------------------------------------------------------------------
// ula_sequenciador
//
// Operator-side initiator for the ALU. A debounced push button steps the
// operator through operand entry (A, then B together with operation and
// mode). The block then issues the request to the ALU over a valid/ready
// handshake, waits for the result pulse and holds result and flags for
// display until the next press. A watchdog aborts the transaction if the
// ALU does not answer in time.
//
// Parameters
//   LARGURA          operand width
//   DEBOUNCE_CICLOS  consecutive stable cycles needed to accept a button change
//   TIMEOUT          maximum cycles from entering EXECUTA until the result
//
// Ports
//   CLOCK_50      system clock
//   reset_n       asynchronous active-low reset
//   i_botao       raw push button, active-low, asynchronous to the clock
//   i_dado        operand value from the switches
//   i_operacao    operation code from the switches
//   i_modo        1 = logic operation, 0 = arithmetic operation
//   o_A, o_B      operands to the ALU
//   o_operacao    operation code to the ALU
//   o_modo        mode to the ALU
//   o_valido      request valid toward the ALU
//   i_pronto      ALU accepts the request
//   i_res_valido  ALU result valid (one-cycle pulse)
//   i_resultado   ALU result
//   i_overflow    ALU overflow flag
//   i_zero        ALU zero flag
//   o_resultado   captured result
//   o_overflow    captured overflow flag
//   o_zero        captured zero flag
//   o_erro        set when the ALU failed to answer within TIMEOUT cycles
//   o_estado      current state code, for the LEDs
// ---------------------------------------------------------------------------
module ula_sequenciador #(
  parameter int LARGURA         = 6,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int TIMEOUT         = 255
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               i_botao,
  input  logic [LARGURA-1:0] i_dado,
  input  logic [2:0]         i_operacao,
  input  logic               i_modo,
  output logic [LARGURA-1:0] o_A,
  output logic [LARGURA-1:0] o_B,
  output logic [2:0]         o_operacao,
  output logic               o_modo,
  output logic               o_valido,
  input  logic               i_pronto,
  input  logic               i_res_valido,
  input  logic [6:0]         i_resultado,
  input  logic               i_overflow,
  input  logic               i_zero,
  output logic [6:0]         o_resultado,
  output logic               o_overflow,
  output logic               o_zero,
  output logic               o_erro,
  output logic [2:0]         o_estado
);

  localparam int DEB_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Last count value before the threshold: the change is accepted on the
  // DEBOUNCE_CICLOS-th consecutive differing cycle.
  localparam logic [DEB_W-1:0] DEB_ULTIMO = DEB_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [TMO_W-1:0] TMO_ULTIMO = TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] CARREGA_A = 3'd0;
  localparam logic [2:0] CARREGA_B = 3'd1;
  localparam logic [2:0] EXECUTA   = 3'd2;
  localparam logic [2:0] AGUARDA   = 3'd3;
  localparam logic [2:0] EXIBE     = 3'd4;

  logic             sync_p0;
  logic             sync_p1;
  logic             deb_nivel;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_aceita;
  logic             pressao;

  logic [2:0]       estado;
  logic [TMO_W-1:0] tmo_cnt;
  logic             estourou;

  // ---- stage p0/p1: two-flop synchronizer, then debounce counter ----------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      deb_nivel <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      sync_p0 <= i_botao;
      sync_p1 <= sync_p0;
      if (sync_p1 != deb_nivel) begin
        if (deb_cnt == DEB_ULTIMO) begin
          deb_nivel <= sync_p1;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        // Any bounce back to the accepted level restarts the qualification.
        deb_cnt <= '0;
      end
    end
  end

  // The press pulse is the cycle on which a falling level is accepted, so the
  // FSM acts on the same edge the debounced level drops; releases are silent.
  assign deb_aceita = (sync_p1 != deb_nivel) && (deb_cnt == DEB_ULTIMO);
  assign pressao    = deb_aceita && !sync_p1;

  // Watchdog hits on the TIMEOUT-th cycle spent in EXECUTA/AGUARDA.
  assign estourou = (tmo_cnt == TMO_ULTIMO);

  // ---- sequencer: operand capture, handshake, result capture --------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= CARREGA_A;
      tmo_cnt     <= '0;
      o_A         <= '0;
      o_B         <= '0;
      o_operacao  <= '0;
      o_modo      <= 1'b0;
      o_valido    <= 1'b0;
      o_resultado <= '0;
      o_overflow  <= 1'b0;
      o_zero      <= 1'b0;
      o_erro      <= 1'b0;
    end else begin
      case (estado)
        CARREGA_A: begin
          if (pressao) begin
            o_A    <= i_dado;
            estado <= CARREGA_B;
          end
        end

        CARREGA_B: begin
          if (pressao) begin
            o_B        <= i_dado;
            o_operacao <= i_operacao;
            o_modo     <= i_modo;
            // Valid is raised together with the state change so it is
            // already high on the first EXECUTA cycle.
            o_valido   <= 1'b1;
            tmo_cnt    <= '0;
            estado     <= EXECUTA;
          end
        end

        EXECUTA: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (estourou) begin
            o_erro      <= 1'b1;
            o_valido    <= 1'b0;
            o_resultado <= '0;
            o_overflow  <= 1'b0;
            o_zero      <= 1'b0;
            estado      <= EXIBE;
          end else if (o_valido && i_pronto) begin
            o_valido <= 1'b0;
            estado   <= AGUARDA;
          end
        end

        AGUARDA: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A result arriving on the watchdog cycle still counts.
          if (i_res_valido) begin
            o_resultado <= i_resultado;
            o_overflow  <= i_overflow;
            o_zero      <= i_zero;
            estado      <= EXIBE;
          end else if (estourou) begin
            o_erro      <= 1'b1;
            o_valido    <= 1'b0;
            o_resultado <= '0;
            o_overflow  <= 1'b0;
            o_zero      <= 1'b0;
            estado      <= EXIBE;
          end
        end

        EXIBE: begin
          if (pressao) begin
            o_erro <= 1'b0;
            estado <= CARREGA_A;
          end
        end

        default: estado <= CARREGA_A;
      endcase
    end
  end

  assign o_estado = estado;

endmodule
